// File: rtl/fetch_pkg.sv
// Shared constants and the fetch-entry layout for the instruction fetch queue.
// Optional same-cycle bypass is enabled by defining FETCH_QUEUE_BYPASS_EN.
package fetch_pkg;

    localparam int          PC_INC   = 4;
    localparam logic [31:0] INST_NOP = 32'h0000_0000;

    // Default-width entry; modules with another AW build the same {inst, pc} layout.
    localparam int FETCH_AW = 32;

    typedef struct packed {
        logic [FETCH_AW-1:0] inst;
        logic [FETCH_AW-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fq_fifo.sv
// Circular DEPTH-entry store for fetched {inst, pc} pairs with head/tail
// pointers, an occupancy counter and a single-cycle flush.
module fq_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                   clk,
    input  logic                   clrn,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  entry_t                 wr_entry,
    output entry_t                 rd_entry,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);

    entry_t          mem [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [PW:0]     count_q;

    // NOTE: the entry array has no reset; validity lives entirely in head/tail/count,
    // so clearing the payload would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= wr_entry;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // its pre-edge value regardless of statement order.
    always_ff @(posedge clk) begin
        if (clrn) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else if (flush) begin
            head    <= tail;
            count_q <= '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the modulo wrap.
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rd_entry = mem[head];
    assign count    = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch stage: PC register, fetch/pop control and a decoupling queue
// toward decode. Define FETCH_QUEUE_BYPASS_EN for same-cycle presentation when empty.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int            AW       = 32,
    parameter int            DEPTH    = 4,
    parameter int            IMEM_AW  = 6,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   clrn,
    input  logic                   redirect,
    input  logic [AW-1:0]          redirect_pc,
    output logic [IMEM_AW-1:0]     imem_addr,
    input  logic [AW-1:0]          imem_rdata,
    output logic                   if_valid,
    input  logic                   id_ready,
    output logic [AW-1:0]          if_inst,
    output logic [AW-1:0]          if_pc,
    output logic [AW-1:0]          if_pc4,
    output logic [$clog2(DEPTH):0] fq_count
);

    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [AW-1:0] inst;
        logic [AW-1:0] pc;
    } entry_t;

    logic [AW-1:0] pc;
    logic [CW-1:0] count;
    entry_t        head_entry;
    entry_t        push_entry;
    logic          empty;
    logic          full;
    logic          bypass;
    logic          pop;
    logic          fetch;
    logic          push;
    logic          fifo_pop;

    assign imem_addr  = pc[IMEM_AW+1:2];
    assign empty      = (count == '0);
    assign full       = (count == CW'(DEPTH));
    assign push_entry = '{inst: imem_rdata, pc: pc};

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        bypass   = 1'b0;
        if_valid = !redirect && !empty;
        if_inst  = empty ? AW'(INST_NOP) : head_entry.inst;
        if_pc    = head_entry.pc;
`ifdef FETCH_QUEUE_BYPASS_EN
        // Empty queue: hand the word being fetched straight to decode.
        if (empty && !redirect) begin
            bypass   = 1'b1;
            if_valid = 1'b1;
            if_inst  = imem_rdata;
            if_pc    = pc;
        end
`endif
        pop      = if_valid && id_ready && !redirect;
        fetch    = !redirect && (!full || pop);
        push     = fetch && !(bypass && pop);
        fifo_pop = pop && !bypass;
    end

    assign if_pc4   = if_pc + AW'(PC_INC);
    assign fq_count = count;

    // Reset beats redirect, redirect beats the sequential fetch advance.
    always_ff @(posedge clk) begin
        if (clrn) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= redirect_pc;
        end else if (fetch) begin
            pc <= pc + AW'(PC_INC);
        end
    end

    fq_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk      (clk),
        .clrn     (clrn),
        .flush    (redirect),
        .push     (push),
        .pop      (fifo_pop),
        .wr_entry (push_entry),
        .rd_entry (head_entry),
        .count    (count)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a 32-bit instance for flow, back-pressure and
// redirect cases, plus an 8-bit instance starting at 0xFC for PC wrap.
module tb_fetch_queue;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp32_t;

    typedef struct {
        logic [7:0] pc;
        logic [7:0] inst;
    } exp8_t;

    logic        clk = 1'b0;
    logic        clrn;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic [5:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
    logic [2:0]  fq_count;

    logic        clrn8;
    logic        redirect8;
    logic [7:0]  redirect_pc8;
    logic        id_ready8;
    logic [5:0]  imem_addr8;
    logic [7:0]  imem_rdata8;
    logic        if_valid8;
    logic [7:0]  if_inst8;
    logic [7:0]  if_pc8;
    logic [7:0]  if_pc48;
    logic [2:0]  fq_count8;

    int n_checks = 0;
    int n_pass   = 0;

    exp32_t sb32[$];
    exp8_t  sb8[$];

    always #5 clk = ~clk;

    // Instruction memory models: the word encodes its own index.
    assign imem_rdata  = 32'hC0DE_0000 | 32'(imem_addr);
    assign imem_rdata8 = {2'b10, imem_addr8};

    fetch_queue #(
        .AW       (32),
        .DEPTH    (4),
        .IMEM_AW  (6),
        .RESET_PC (32'h0)
    ) u_dut (
        .clk         (clk),
        .clrn        (clrn),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .id_ready    (id_ready),
        .if_inst     (if_inst),
        .if_pc       (if_pc),
        .if_pc4      (if_pc4),
        .fq_count    (fq_count)
    );

    fetch_queue #(
        .AW       (8),
        .DEPTH    (4),
        .IMEM_AW  (6),
        .RESET_PC (8'hFC)
    ) u_dut8 (
        .clk         (clk),
        .clrn        (clrn8),
        .redirect    (redirect8),
        .redirect_pc (redirect_pc8),
        .imem_addr   (imem_addr8),
        .imem_rdata  (imem_rdata8),
        .if_valid    (if_valid8),
        .id_ready    (id_ready8),
        .if_inst     (if_inst8),
        .if_pc       (if_pc8),
        .if_pc4      (if_pc48),
        .fq_count    (fq_count8)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clrn     = 1'b1;
        redirect = 1'b0;
        id_ready = 1'b0;
        tick();
        clrn = 1'b0;
    endtask

    task automatic expect32(input logic [31:0] pc);
        exp32_t e;
        e.pc   = pc;
        e.inst = 32'hC0DE_0000 | {26'd0, pc[7:2]};
        sb32.push_back(e);
    endtask

    task automatic expect8(input logic [7:0] pc);
        exp8_t e;
        e.pc   = pc;
        e.inst = {2'b10, pc[7:2]};
        sb8.push_back(e);
    endtask

    // Monitor: every accepted head entry is compared against the scoreboard front.
    always @(negedge clk) begin
        exp32_t e32;
        exp8_t  e8;
        logic [31:0] pc4_32;
        logic [7:0]  pc4_8;
        if (if_valid === 1'b1 && id_ready === 1'b1 && redirect === 1'b0) begin
            if (sb32.size() == 0) begin
                check("pop32_unexpected", {32'd0, if_pc}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e32    = sb32.pop_front();
                pc4_32 = e32.pc + 32'd4;
                check("pop32_pc",   if_pc,   e32.pc);
                check("pop32_inst", if_inst, e32.inst);
                check("pop32_pc4",  if_pc4,  pc4_32);
            end
        end
        if (if_valid8 === 1'b1 && id_ready8 === 1'b1 && redirect8 === 1'b0) begin
            if (sb8.size() == 0) begin
                check("pop8_unexpected", {56'd0, if_pc8}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e8    = sb8.pop_front();
                pc4_8 = e8.pc + 8'd4;
                check("pop8_pc",   if_pc8,   e8.pc);
                check("pop8_inst", if_inst8, e8.inst);
                check("pop8_pc4",  if_pc48,  pc4_8);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clrn         = 1'b1;
        redirect     = 1'b0;
        redirect_pc  = '0;
        id_ready     = 1'b0;
        clrn8        = 1'b1;
        redirect8    = 1'b0;
        redirect_pc8 = '0;
        id_ready8    = 1'b0;
        tick();

        // Reset then steady flow: 0x0, 0x4, 0x8, 0xC.
        do_reset();
        id_ready = 1'b1;
        expect32(32'h0);
        expect32(32'h4);
        expect32(32'h8);
        expect32(32'hC);
        @(negedge clk);
        check("rst_if_valid",  if_valid,  1'b0);
        check("rst_fq_count",  fq_count,  3'd0);
        check("rst_imem_addr", imem_addr, 6'd0);
        repeat (5) tick();
        id_ready = 1'b0;
        @(negedge clk);
        check("flow_drained",  sb32.size(), 0);
        check("flow_fq_count", fq_count,    3'd1);

        // Fill under back-pressure: queue full, fetch address frozen at 4.
        do_reset();
        repeat (4) tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("fill_imem_addr", imem_addr, 6'd4);
            check("fill_fq_count",  fq_count,  3'd4);
            check("fill_if_valid",  if_valid,  1'b1);
            check("fill_head_pc",   if_pc,     32'h0);
            tick();
        end

        // Full with simultaneous push and pop.
        id_ready = 1'b1;
        expect32(32'h0);
        tick();
        id_ready = 1'b0;
        @(negedge clk);
        check("full_pp_fq_count",  fq_count,  3'd4);
        check("full_pp_head_pc",   if_pc,     32'h4);
        check("full_pp_imem_addr", imem_addr, 6'd5);
        check("full_pp_drained",   sb32.size(), 0);

        // Redirect with three entries queued.
        do_reset();
        repeat (3) tick();
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        id_ready    = 1'b1;
        expect32(32'h40);
        expect32(32'h44);
        @(negedge clk);
        check("redir_if_valid", if_valid, 1'b0);
        check("redir_fq_count", fq_count, 3'd3);
        tick();
        redirect = 1'b0;
        @(negedge clk);
        check("redir_next_fq_count",  fq_count,  3'd0);
        check("redir_next_if_valid",  if_valid,  1'b0);
        check("redir_next_imem_addr", imem_addr, 6'h10);
        repeat (3) tick();
        id_ready = 1'b0;
        @(negedge clk);
        check("redir_drained", sb32.size(), 0);

        // Reset and redirect together: reset wins.
        do_reset();
        repeat (2) tick();
        clrn        = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h80;
        tick();
        clrn     = 1'b0;
        redirect = 1'b0;
        id_ready = 1'b1;
        expect32(32'h0);
        expect32(32'h4);
        @(negedge clk);
        check("rst_redir_imem_addr", imem_addr, 6'd0);
        check("rst_redir_fq_count",  fq_count,  3'd0);
        check("rst_redir_if_valid",  if_valid,  1'b0);
        repeat (3) tick();
        id_ready = 1'b0;
        @(negedge clk);
        check("rst_redir_drained",  sb32.size(), 0);
        check("rst_redir_fq_final", fq_count,    3'd1);

        // PC wrap on the 8-bit instance: 0xFC then 0x00.
        tick();
        clrn8     = 1'b0;
        id_ready8 = 1'b1;
        expect8(8'hFC);
        expect8(8'h00);
        @(negedge clk);
        check("wrap_rst_if_valid",  if_valid8,  1'b0);
        check("wrap_rst_fq_count",  fq_count8,  3'd0);
        check("wrap_rst_imem_addr", imem_addr8, 6'h3F);
        repeat (3) tick();
        id_ready8 = 1'b0;
        @(negedge clk);
        check("wrap_drained",   sb8.size(), 0);
        check("wrap_fq_count",  fq_count8,  3'd1);
        check("wrap_imem_addr", imem_addr8, 6'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
